// File: rtl/polyunit_pkg.sv
// Shared encodings for the polynomial-unit sequencer: modes, butterfly ops, FSM states.
// Holds no logic apart from the pass-count helper, so it adds no latency.
// No handshake of its own. Define POLYUNIT_SCALE_EN to add the INTT scale pass.
package polyunit_pkg;

  typedef enum logic [1:0] {
    MODE_NOP  = 2'b00,
    MODE_NTT  = 2'b01,
    MODE_INTT = 2'b10,
    MODE_BYP  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    OP_CT    = 2'b00,
    OP_GS    = 2'b01,
    OP_SCALE = 2'b10,
    OP_PASS  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Number of full passes over the coefficient RAM for a given mode
  function automatic int unsigned num_passes(input mode_e m, input int unsigned logn);
    case (m)
      MODE_NTT:  return logn - 1;
`ifdef POLYUNIT_SCALE_EN
      MODE_INTT: return logn;
`else
      MODE_INTT: return logn - 1;
`endif
      MODE_BYP:  return 1;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/polyunit_dly.sv
// Write-back delay line: carries {valid, addr_a, addr_b} from read issue to write-back.
// Latency is exactly BF_LAT cycles, and the line advances every cycle.
// It has no stall input. inflight flags valid entries that have not yet reached the output.
module polyunit_dly #(
  parameter int BF_LAT = 4,
  parameter int ADDWID = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [ADDWID-1:0] in_a,
  input  logic [ADDWID-1:0] in_b,
  output logic              out_vld,
  output logic [ADDWID-1:0] out_a,
  output logic [ADDWID-1:0] out_b,
  output logic              inflight
);

  localparam logic [BF_LAT-1:0] LAST_BIT = (BF_LAT)'(1) << (BF_LAT - 1);

  logic [BF_LAT-1:0] vld_q;
  logic [ADDWID-1:0] a_q [BF_LAT];
  logic [ADDWID-1:0] b_q [BF_LAT];

  // Shift register. Reset clears every stage so that no stale write-back escapes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld;
      a_q[0]   <= in_a;
      b_q[0]   <= in_b;
      for (int i = 1; i < BF_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        a_q[i]   <= a_q[i-1];
        b_q[i]   <= b_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[BF_LAT-1];
  assign out_a    = a_q[BF_LAT-1];
  assign out_b    = b_q[BF_LAT-1];
  assign inflight = |(vld_q & ~LAST_BIT);

endmodule

// File: rtl/polyunit_seq.sv
// NTT/INTT/bypass butterfly address sequencer. Write-back follows each issue after BF_LAT cycles.
// First rd_en comes 1 cycle after start is accepted. A layer boundary waits for the layer's last write-back.
// hold stalls issue only while in ISSUE. POLYUNIT_SCALE_EN appends an INTT scale pass.
module polyunit_seq
  import polyunit_pkg::*;
#(
  parameter int LOGN   = 8,
  parameter int BF_LAT = 4,
  parameter int ADDWID = LOGN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDWID-1:0] rd_addr_a,
  output logic [ADDWID-1:0] rd_addr_b,
  output logic [LOGN-2:0]   zeta_idx,
  output logic [1:0]        bf_op,
  output logic              wr_en,
  output logic [ADDWID-1:0] wr_addr_a,
  output logic [ADDWID-1:0] wr_addr_b
);

  localparam int HALF = 1 << (LOGN - 1);
  localparam int CW   = LOGN - 1;
  localparam int LW   = $clog2(LOGN + 1);

  state_e        state_q;
  mode_e         mode_q;
  logic [LW-1:0] layer_q;
  logic [LW-1:0] passes_q;
  logic [CW-1:0] cnt_q;
  logic          inflight;

  logic [31:0]   sh, grp, off, a32, b32, z32;
  op_e           op_w;

  // Map (layer, butterfly count) to operand pair, twiddle index and op code
  always_comb begin
    op_w = OP_PASS;
    sh   = 32'(LOGN - 1);
    z32  = '0;
    case (mode_q)
      MODE_NTT: begin
        op_w = OP_CT;
        sh   = 32'(LOGN - 1) - 32'(layer_q);
      end
      MODE_INTT: begin
        op_w = OP_GS;
        sh   = 32'(layer_q) + 32'd1;
`ifdef POLYUNIT_SCALE_EN
        if (32'(layer_q) == 32'(LOGN - 1)) begin
          op_w = OP_SCALE;
          sh   = 32'(LOGN - 1);
        end
`endif
      end
      default: ;
    endcase
    grp = 32'(cnt_q) >> sh;
    off = 32'(cnt_q) & ((32'd1 << sh) - 32'd1);
    a32 = (grp << (sh + 32'd1)) | off;
    b32 = a32 + (32'd1 << sh);
    if (op_w == OP_CT)
      z32 = (32'd1 << layer_q) + grp;
    else if (op_w == OP_GS)
      z32 = (32'(HALF) >> layer_q) - 32'd1 - grp;
  end

  // Control FSM with registered issue outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_NOP;
      layer_q   <= '0;
      passes_q  <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      zeta_idx  <= '0;
      bf_op     <= '0;
    end else begin
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q   <= mode_e'(mode);
            passes_q <= LW'(num_passes(mode_e'(mode), LOGN));
            layer_q  <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= (mode == MODE_NOP) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (!hold) begin
            rd_en     <= 1'b1;
            rd_addr_a <= ADDWID'(a32);
            rd_addr_b <= ADDWID'(b32);
            zeta_idx  <= CW'(z32);
            bf_op     <= op_w;
            if (cnt_q == CW'(HALF - 1)) begin
              cnt_q   <= '0;
              layer_q <= layer_q + LW'(1);
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DRAIN: begin
          // The last write-back of the layer is on wr_en now, so the next read cannot hit stale data
          if (!rd_en && !inflight) begin
            if (layer_q == passes_q) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= IDLE;
            end else begin
              rd_en     <= 1'b1;
              rd_addr_a <= ADDWID'(a32);
              rd_addr_b <= ADDWID'(b32);
              zeta_idx  <= CW'(z32);
              bf_op     <= op_w;
              cnt_q     <= CW'(1);
              state_q   <= ISSUE;
            end
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  polyunit_dly #(.BF_LAT(BF_LAT), .ADDWID(ADDWID)) u_dly (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_en),
    .in_a     (rd_addr_a),
    .in_b     (rd_addr_b),
    .out_vld  (wr_en),
    .out_a    (wr_addr_a),
    .out_b    (wr_addr_b),
    .inflight (inflight)
  );

endmodule

// File: tb/tb_polyunit_seq.sv
// Directed bench for polyunit_seq (LOGN=8, BF_LAT=4). The scale-pass checks follow POLYUNIT_SCALE_EN.
// Each run logs issue and write-back events per cycle, counted from the cycle in which start is accepted.
// Expected values are hand-derived constants plus a reference loop nest for each schedule.
module tb_polyunit_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       hold;
  logic       busy, done, rd_en, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] zeta_idx;
  logic [1:0] bf_op;

  polyunit_seq #(.LOGN(8), .BF_LAT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .zeta_idx  (zeta_idx),
    .bf_op     (bf_op),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int rd_q[$];
  int rd_cyc[$];
  int wr_q[$];
  int wr_cyc[$];
  int exp_q[$];
  int done_cyc, busy0, busy_at_done;

  function automatic int pk(input int op, input int z, input int a, input int b);
    return (op << 24) | (z << 16) | (a << 8) | b;
  endfunction

  function automatic int rd_at(input int i);
    if (i < 0 || i >= rd_q.size()) return -1;
    return rd_q[i];
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference schedule, written as the textbook loop nests
  task automatic build_exp(input logic [1:0] m);
    int k;
    exp_q.delete();
    if (m == 2'b01) begin
      k = 1;
      for (int len = 128; len >= 2; len = len / 2)
        for (int st = 0; st < 256; st += 2 * len) begin
          for (int j = st; j < st + len; j++) exp_q.push_back(pk(0, k, j, j + len));
          k++;
        end
    end else if (m == 2'b10) begin
      k = 127;
      for (int len = 2; len <= 128; len = len * 2)
        for (int st = 0; st < 256; st += 2 * len) begin
          for (int j = st; j < st + len; j++) exp_q.push_back(pk(1, k, j, j + len));
          k--;
        end
`ifdef POLYUNIT_SCALE_EN
      for (int j = 0; j < 128; j++) exp_q.push_back(pk(2, 0, j, j + 128));
`endif
    end else if (m == 2'b11) begin
      for (int j = 0; j < 128; j++) exp_q.push_back(pk(3, 0, j, j + 128));
    end
  endtask

  function automatic int sched_err();
    int e;
    e = (rd_q.size() > exp_q.size()) ? rd_q.size() - exp_q.size() : exp_q.size() - rd_q.size();
    for (int i = 0; i < rd_q.size() && i < exp_q.size(); i++)
      if (rd_q[i] != exp_q[i]) e++;
    return e;
  endfunction

  // Every write-back must mirror its issue exactly 4 cycles later
  function automatic int wr_err();
    int e;
    e = (rd_q.size() > wr_q.size()) ? rd_q.size() - wr_q.size() : wr_q.size() - rd_q.size();
    for (int i = 0; i < rd_q.size() && i < wr_q.size(); i++)
      if (wr_q[i] != (rd_q[i] & 32'hFFFF) || wr_cyc[i] != rd_cyc[i] + 4) e++;
    return e;
  endfunction

  // A layer's first issue must come exactly one cycle after the previous layer's last write-back
  function automatic int raw_err();
    int e;
    e = 0;
    for (int l = 1; l * 128 < rd_q.size(); l++)
      if (l * 128 - 1 >= wr_cyc.size() || rd_cyc[l * 128] != wr_cyc[l * 128 - 1] + 1) e++;
    return e;
  endfunction

  task automatic run(input logic [1:0] m, input int hold_from, input int busy_start_at);
    rd_q.delete(); rd_cyc.delete(); wr_q.delete(); wr_cyc.delete();
    done_cyc = -1; busy0 = -1; busy_at_done = -1;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = m ^ 2'b11;
    for (int c = 0; c < 1400; c++) begin
      @(negedge clk);
      if (c == 0) busy0 = int'(busy);
      if (rd_en) begin
        rd_q.push_back(pk(int'(bf_op), int'(zeta_idx), int'(rd_addr_a), int'(rd_addr_b)));
        rd_cyc.push_back(c);
      end
      if (wr_en) begin
        wr_q.push_back(pk(0, 0, int'(wr_addr_a), int'(wr_addr_b)));
        wr_cyc.push_back(c);
      end
      hold  = (hold_from >= 0) && (c + 1 >= hold_from) && (c + 1 < hold_from + 10);
      start = (c + 1 == busy_start_at);
      if (start) mode = 2'b10;
      if (done) begin
        done_cyc = c;
        busy_at_done = int'(busy);
        break;
      end
      @(posedge clk);
    end
    hold  = 1'b0;
    start = 1'b0;
  endtask

  function automatic int out_sum();
    return int'(busy) + int'(done) + int'(rd_en) + int'(wr_en) + int'(rd_addr_a) + int'(rd_addr_b)
         + int'(zeta_idx) + int'(bf_op) + int'(wr_addr_a) + int'(wr_addr_b);
  endfunction

  initial begin
    int cnt;
    rst = 1'b0; start = 1'b0; mode = 2'b00; hold = 1'b0;
    #1;
    check("reset_outputs", out_sum(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // NTT
    build_exp(2'b01);
    run(2'b01, -1, -1);
    check("ntt_count", rd_q.size(), 896);
    check("ntt_first", rd_at(0), pk(0, 1, 0, 128));
    check("ntt_l1_g0", rd_at(128), pk(0, 2, 0, 64));
    check("ntt_l1_g1", rd_at(192), pk(0, 3, 128, 192));
    check("ntt_last", rd_at(895), pk(0, 127, 253, 255));
    check("ntt_done_cyc", done_cyc, 925);
    check("ntt_busy_c0", busy0, 1);
    check("ntt_busy_at_done", busy_at_done, 0);
    check("ntt_sched", sched_err(), 0);
    check("ntt_wr_trace", wr_err(), 0);
    check("ntt_layer_gap", raw_err(), 0);

    // INTT
    build_exp(2'b10);
    run(2'b10, -1, -1);
    check("intt_first", rd_at(0), pk(1, 127, 0, 2));
    check("intt_last_gs", rd_at(895), pk(1, 1, 127, 255));
    check("intt_sched", sched_err(), 0);
    check("intt_wr_trace", wr_err(), 0);
`ifdef POLYUNIT_SCALE_EN
    check("intt_count", rd_q.size(), 1024);
    check("intt_scale_first", rd_at(896), pk(2, 0, 0, 128));
    check("intt_scale_last", rd_at(1023), pk(2, 0, 127, 255));
    check("intt_done_cyc", done_cyc, 1057);
`else
    check("intt_count", rd_q.size(), 896);
    check("intt_done_cyc", done_cyc, 925);
`endif

    // Bypass
    build_exp(2'b11);
    run(2'b11, -1, -1);
    check("byp_count", rd_q.size(), 128);
    check("byp_first", rd_at(0), pk(3, 0, 0, 128));
    check("byp_last", rd_at(127), pk(3, 0, 127, 255));
    check("byp_done_cyc", done_cyc, 133);
    check("byp_wr_trace", wr_err(), 0);

    // Hold for 10 cycles in the middle of layer 3 (its issues occupy cycles 397..524)
    build_exp(2'b01);
    run(2'b01, 450, -1);
    cnt = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] >= 450 && rd_cyc[i] < 460) cnt++;
    check("hold_no_issue", cnt, 0);
    check("hold_sched", sched_err(), 0);
    check("hold_layer_gap", raw_err(), 0);
    check("hold_done_cyc", done_cyc, 935);

    // start pulse (and a mode change) while busy must not disturb the schedule
    build_exp(2'b01);
    run(2'b01, -1, 300);
    check("busy_start_sched", sched_err(), 0);
    check("busy_start_done", done_cyc, 925);

    // Nop
    run(2'b00, -1, -1);
    check("nop_done_cyc", done_cyc, 1);
    check("nop_rd_wr", rd_q.size() + wr_q.size(), 0);

    // Asynchronous reset in the middle of an NTT
    @(negedge clk);
    start = 1'b1; mode = 2'b01;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    check("pre_rst_wr_active", int'(wr_en), 1);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_outputs", out_sum(), 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      cnt += int'(wr_en) + int'(rd_en) + int'(busy);
    end
    check("post_rst_quiet", cnt, 0);
    build_exp(2'b11);
    run(2'b11, -1, -1);
    check("post_rst_sched", sched_err(), 0);
    check("post_rst_done", done_cyc, 133);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
